// File: rtl/seq_div.sv
// seq_div: iterative radix-2 restoring divider.
// One quotient bit per cycle; fixed latency for all operands.
module seq_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic             armed_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dm_q;
  logic [WIDTH-1:0] raw_q;
  logic             qs_q;
  logic             rs_q;
  logic             dz_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH+1:0] trial;

  // Operand magnitudes and the trial subtraction for one step.
  // The extra top bit keeps the compare exact for any divisor.
  always_comb begin
    accept = (state_q == IDLE) && start && !armed_q;
    a_neg  = is_signed & dividend[WIDTH-1];
    b_neg  = is_signed & divisor[WIDTH-1];
    a_mag  = a_neg ? -dividend : dividend;
    b_mag  = b_neg ? -divisor : divisor;
    trial  = {1'b0, r_q, q_q[WIDTH-1]} - {2'b00, dm_q};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and status outputs.
  // An accepted start spends one armed cycle in IDLE first.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = armed_q;
        if (armed_q) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, shift/subtract iteration and result load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q   <= 1'b0;
      r_q       <= '0;
      q_q       <= '0;
      dm_q      <= '0;
      raw_q     <= '0;
      qs_q      <= 1'b0;
      rs_q      <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      armed_q <= accept;
      if (accept) begin
        r_q      <= '0;
        q_q      <= a_mag;
        dm_q     <= b_mag;
        raw_q    <= dividend;
        qs_q     <= a_neg ^ b_neg;
        rs_q     <= a_neg;
        dz_q     <= (divisor == '0);
        cnt_q    <= CNT_W'(WIDTH);
        div_zero <= 1'b0;
      end else if (state_q == CALC) begin
        if (!trial[WIDTH+1]) r_q <= trial[WIDTH-1:0];
        else r_q <= {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        q_q   <= {q_q[WIDTH-2:0], ~trial[WIDTH+1]};
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (state_q == FIX) begin
        if (dz_q) begin
          quotient  <= '0;
          remainder <= raw_q;
          div_zero  <= 1'b1;
        end else begin
          quotient  <= qs_q ? -q_q : q_q;
          remainder <= rs_q ? -r_q : r_q;
          div_zero  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed scoreboard bench for seq_div.
// Expected results are queued at launch, compared at done.
module tb_seq_div;

  localparam int W = 32;
  localparam int LAT = 35;

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  seq_div #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input string tag,
                      input logic [W-1:0] q,
                      input logic [W-1:0] r,
                      input logic dz);
    exp_t e;
    e.tag = tag;
    e.q   = q;
    e.r   = r;
    e.dz  = dz;
    sb.push_back(e);
  endtask

  // Called at the negedge after the accepting edge (n = 1).
  task automatic finish_div();
    int   n;
    exp_t e;
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk({e.tag, "_done"}, 64'(done), 64'(1));
    chk({e.tag, "_lat"}, 64'(n), 64'(LAT));
    chk({e.tag, "_busy0"}, 64'(busy), 64'(0));
    chk({e.tag, "_q"}, 64'(quotient), 64'(e.q));
    chk({e.tag, "_r"}, 64'(remainder), 64'(e.r));
    chk({e.tag, "_dz"}, 64'(div_zero), 64'(e.dz));
  endtask

  task automatic run(input string tag,
                     input logic sgn,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] q,
                     input logic [W-1:0] r,
                     input logic dz);
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    push(tag, q, r, dz);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = ~a;
    divisor  = b + 1;
    chk({tag, "_busy1"}, 64'(busy), 64'(1));
    finish_div();
  endtask

  initial begin
    bit seen;
    reset     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_q", 64'(quotient), 64'(0));
    chk("rst_r", 64'(remainder), 64'(0));
    chk("rst_dz", 64'(div_zero), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    run("u100_7", 0, 100, 7, 14, 2, 0);
    run("s_m100_7", 1, 32'hFFFFFF9C, 7,
        32'hFFFFFFF2, 32'hFFFFFFFE, 0);
    run("s_100_m7", 1, 100, 32'hFFFFFFF9,
        32'hFFFFFFF2, 2, 0);
    run("u_max_1", 0, 32'hFFFFFFFF, 1,
        32'hFFFFFFFF, 0, 0);
    run("s_ovf", 1, 32'h80000000, 32'hFFFFFFFF,
        32'h80000000, 0, 0);
    run("u_big", 0, 32'hFFFFFFFE, 32'hFFFFFFFF,
        0, 32'hFFFFFFFE, 0);
    run("u_dz", 0, 32'h12345678, 0,
        0, 32'h12345678, 1);
    run("s_dz", 1, 32'h12345678, 0,
        0, 32'h12345678, 1);
    run("u9_3", 0, 9, 3, 3, 0, 0);

    // start held high across two divisions
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 9;
    divisor   = 2;
    start     = 1'b1;
    push("hold1", 4, 1, 0);
    @(posedge clk);
    @(negedge clk);
    chk("hold1_busy1", 64'(busy), 64'(1));
    dividend = 100;
    divisor  = 3;
    finish_div();
    dividend = 9;
    divisor  = 2;
    push("hold2", 4, 1, 0);
    @(negedge clk);
    chk("hold_gap", 64'(busy), 64'(0));
    @(negedge clk);
    chk("hold2_busy1", 64'(busy), 64'(1));
    finish_div();
    start = 1'b0;

    // reset aborts a division in flight
    @(negedge clk);
    dividend = 100;
    divisor  = 7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_q", 64'(quotient), 64'(0));
    chk("abort_r", 64'(remainder), 64'(0));
    chk("abort_dz", 64'(div_zero), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b1;
      if (done) seen = 1'b1;
    end
    chk("abort_nodone", 64'(seen), 64'(0));
    run("u15_4", 0, 15, 4, 3, 3, 0);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
